io_input_port: RTL and testbench
================================

// Module: io_input_port
// PURPOSE
//  Memory-mapped input peripheral for the single-cycle CPU; the read-side counterpart of the io_output block.
//  - Synchronises and debounces two 32-bit external input buses (switches/keys).
//  - Returns their values, or a change-status word, to the CPU load path on a read of the IO address window.
//  - Change flags are sticky and clear on a read of the status register.
// PARAMETERS
//  DEBOUNCE_CYCLES  16  io_clk cycles a synchronised value must differ from the stable value before it is accepted; minimum 1
// PORTS
//  io_clk          in   1   IO clock; all state updates on its rising edge
//  resetn          in   1   asynchronous, active-low reset
//  addr            in   32  CPU byte address; only addr[7:2] is decoded
//  read_io_enable  in   1   CPU load from the IO window this cycle
//  in_port0        in   32  raw external input 0, asynchronous to io_clk
//  in_port1        in   32  raw external input 1, asynchronous to io_clk
//  dataout         out  32  registered read data to CPU load mux
// BEHAVIOUR
//  - Reset (resetn=0, asynchronous) clears every flop:
//    - sync stages, debounce counters, stable values, change flags, dataout all go to 0.
//    - When IO_INPUT_IRQ_EN is defined, irq also goes to 0.
//  - Synchroniser: two flops per bit (s1 <= raw, s2 <= s1).
//  - Debounce, per port, whole word:
//    - If s2 != stable, cnt <= cnt+1.
//    - If s2 == stable, cnt <= 0.
//    - When s2 != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s2 and cnt <= 0.
//    - cnt width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
//  - Latency: a raw change held steady reaches stable on the (DEBOUNCE_CYCLES+2)th rising edge after it settles.
//    - A bounce back to the old value before that edge restarts the count.
//  - Change flags chg[1:0]: chg[n] is set on the edge where stable port n updates.
//  - Address map, decoded on addr[7:2]:
//    - 100000 (80h): stable port0
//    - 100001 (84h): stable port1
//    - 100010 (88h): {30'b0, chg[1:0]}
//    - all other addresses: 32'h0
//  - Read: on a rising edge with read_io_enable=1, dataout <= decoded value (1-cycle latency).
//  - With read_io_enable=0, dataout holds its value.
//  - Status read clears chg on the same edge that captures it into dataout.
//    - If a port updates on that same edge, its flag reads as the old value and is left SET (set wins over clear).
//  - Reads of 80h/84h never modify flags.
//  - Writes are not supported; the block has no write port.
//  - Reset asserted mid-debounce discards the pending count; stable returns to 0.
// CONFIGURATION
//  IO_INPUT_IRQ_EN defined:
//    - Adds output irq (1 bit), a registered OR of chg[1:0].
//    - irq rises one cycle after a flag sets and falls one cycle after the flags clear.
//  IO_INPUT_IRQ_EN undefined: no irq port exists; the CPU must poll 88h.
// STRUCTURE
//  - Shared package io_map_pkg: 6-bit word-offset constants for the whole IO window.
//    - Input: IO_IN0=6'h20, IO_IN1=6'h21, IO_INSTAT=6'h22.
//    - Output: IO_OUT0=6'h2A.
//  - Sub-module io_input_debounce (params WIDTH, DEBOUNCE_CYCLES): synchroniser, counter, stable register, update strobe.
//    - Instantiated once per port.
//  - Top level: address decode, read register, change flags, optional irq.
// TESTING  (bench uses DEBOUNCE_CYCLES=4)
//  1. Reset, then read 80h/84h/88h -> dataout 0 each, one cycle after read_io_enable.
//  2. in_port0 0->32'h0000_00A5, held -> stable updates on edge 6; read 80h -> 32'h0000_00A5; read 88h -> 32'h1.
//  3. in_port1 toggles 32'h1 / 32'h0 every 2 cycles for 20 cycles -> stable port1 stays 0, chg[1]=0.
//  4. Read 88h twice after a port0 update -> first 32'h1, second 32'h0.
//  5. Port1 update on the same edge as a 88h read -> read shows bit1=0; next 88h read -> 32'h2.
//  6. Read 8Ch and A8h -> 32'h0; resetn pulsed low mid-debounce -> all outputs 0 immediately, no stale update afterwards.

Source files
------------

// File: rtl/io_map_pkg.sv
// Word-offset map (addr[7:2]) for the CPU IO window, shared by the input and output peripherals.
package io_map_pkg;

  localparam logic [5:0] IO_IN0    = 6'h20;
  localparam logic [5:0] IO_IN1    = 6'h21;
  localparam logic [5:0] IO_INSTAT = 6'h22;
  localparam logic [5:0] IO_OUT0   = 6'h2A;

  localparam int IO_DATA_W = 32;

endpackage

// File: rtl/io_input_debounce.sv
// Two-flop synchroniser plus whole-word debounce; update pulses on the edge that loads stable.
module io_input_debounce #(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             update
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  assign differ = (s2 != stable);
  assign update = differ && (cnt == CNT_LAST);

  // Any return to the stable value restarts the count, so the counter cannot wrap.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      s1     <= '0;
      s2     <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (update) begin
        stable <= s2;
        cnt    <= '0;
      end else if (differ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input port: two debounced buses plus sticky change flags, read through dataout.
// Optional irq output when IO_INPUT_IRQ_EN is defined.
module io_input_port
  import io_map_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 io_clk,
  input  logic                 resetn,
  input  logic [31:0]          addr,
  input  logic                 read_io_enable,
  input  logic [IO_DATA_W-1:0] in_port0,
  input  logic [IO_DATA_W-1:0] in_port1,
  output logic [IO_DATA_W-1:0] dataout
`ifdef IO_INPUT_IRQ_EN
  ,
  output logic                 irq
`endif
);

  logic [IO_DATA_W-1:0] stable0;
  logic [IO_DATA_W-1:0] stable1;
  logic                 upd0;
  logic                 upd1;
  logic [1:0]           chg;
  logic [5:0]           word_off;
  logic                 status_rd;
  logic [IO_DATA_W-1:0] rd_data;
  logic                 unused_addr_bits;

  assign word_off         = addr[7:2];
  assign unused_addr_bits = ^{addr[31:8], addr[1:0]};
  assign status_rd        = read_io_enable && (word_off == IO_INSTAT);

  io_input_debounce #(.WIDTH(IO_DATA_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .io_clk (io_clk),
    .resetn (resetn),
    .raw    (in_port0),
    .stable (stable0),
    .update (upd0)
  );

  io_input_debounce #(.WIDTH(IO_DATA_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .io_clk (io_clk),
    .resetn (resetn),
    .raw    (in_port1),
    .stable (stable1),
    .update (upd1)
  );

  always_comb begin
    rd_data = '0;
    case (word_off)
      IO_IN0:    rd_data = stable0;
      IO_IN1:    rd_data = stable1;
      IO_INSTAT: rd_data = {30'b0, chg};
      default:   rd_data = '0;
    endcase
  end

  // Set beats clear: an update coinciding with a status read stays pending for the next read.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      chg     <= '0;
      dataout <= '0;
    end else begin
      chg <= (chg & ~{2{status_rd}}) | {upd1, upd0};
      if (read_io_enable) begin
        dataout <= rd_data;
      end
    end
  end

`ifdef IO_INPUT_IRQ_EN
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |chg;
    end
  end
`endif

endmodule

// File: tb/tb_io_input_port.sv
// Directed bench for io_input_port with DEBOUNCE_CYCLES=4: address-decode table plus debounce/flag sequences.
module tb_io_input_port;

  logic        io_clk;
  logic        resetn;
  logic [31:0] addr;
  logic        read_io_enable;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic [31:0] dataout;
`ifdef IO_INPUT_IRQ_EN
  logic        irq;
`endif

  int tests  = 0;
  int failed = 0;

  io_input_port #(.DEBOUNCE_CYCLES(4)) dut (
    .io_clk         (io_clk),
    .resetn         (resetn),
    .addr           (addr),
    .read_io_enable (read_io_enable),
    .in_port0       (in_port0),
    .in_port1       (in_port1),
    .dataout        (dataout)
`ifdef IO_INPUT_IRQ_EN
    ,
    .irq            (irq)
`endif
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  rd_vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: dataout=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Read occupies exactly one rising edge; result is visible just after it.
  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr           = a;
    read_io_enable = 1'b1;
    tick();
    read_io_enable = 1'b0;
    check(name, dataout, exp);
  endtask

  initial begin
    resetn         = 1'b0;
    addr           = '0;
    read_io_enable = 1'b0;
    in_port0       = '0;
    in_port1       = '0;

    // 1. reset state
    ticks(2);
    check("reset_dataout", dataout, 32'h0);
    resetn = 1'b1;
    tick();
    rd(32'h80, 32'h0, "rst_rd80");
    rd(32'h84, 32'h0, "rst_rd84");
    rd(32'h88, 32'h0, "rst_rd88");

    // 2. port0 update lands on edge 6: a read on edge 6 still sees 0, edge 7 sees the new value
    in_port0 = 32'h0000_00A5;
    ticks(5);
    rd(32'h80, 32'h0, "p0_edge6_old");
    rd(32'h80, 32'h0000_00A5, "p0_edge7_new");
    // 4. status sticky until read, then cleared
    rd(32'h88, 32'h1, "stat_first");
    rd(32'h88, 32'h0, "stat_second");

    // 3. bouncing port1 never settles
    for (int i = 0; i < 10; i++) begin
      in_port1 = (i % 2 == 0) ? 32'h1 : 32'h0;
      ticks(2);
    end
    in_port1 = 32'h0;
    ticks(4);
    rd(32'h84, 32'h0, "bounce_p1_stable");
    rd(32'h88, 32'h0, "bounce_no_chg");

    // 5. port1 update on the same edge as a status read
    in_port1 = 32'h0000_1234;
    ticks(5);
    rd(32'h88, 32'h0, "same_edge_old");
    rd(32'h88, 32'h2, "same_edge_kept");
    rd(32'h88, 32'h0, "same_edge_clr");

    // address decode table
    vecs[0] = '{32'h0000_0080, 32'h0000_00A5, "tbl_80"};
    vecs[1] = '{32'h0000_0084, 32'h0000_1234, "tbl_84"};
    vecs[2] = '{32'h0000_0088, 32'h0,         "tbl_88"};
    vecs[3] = '{32'h0000_008C, 32'h0,         "tbl_8C"};
    vecs[4] = '{32'h0000_00A8, 32'h0,         "tbl_A8"};
    vecs[5] = '{32'h0000_0000, 32'h0,         "tbl_00"};
    vecs[6] = '{32'h0000_007C, 32'h0,         "tbl_7C"};
    vecs[7] = '{32'h0000_0180, 32'h0000_00A5, "tbl_180"};
    vecs[8] = '{32'h0000_0081, 32'h0000_00A5, "tbl_81"};
    vecs[9] = '{32'hFFFF_FF87, 32'h0000_1234, "tbl_87"};
    for (int i = 0; i < 10; i++) rd(vecs[i].a, vecs[i].exp, vecs[i].name);

    // 80h/84h reads left flags alone; dataout holds while read_io_enable=0
    rd(32'h80, 32'h0000_00A5, "hold_setup");
    addr = 32'h84;
    ticks(2);
    check("hold_no_enable", dataout, 32'h0000_00A5);

    // 6. reset mid-debounce
    in_port0 = 32'h0000_0F0F;
    ticks(4);
    resetn   = 1'b0;
    in_port1 = 32'h0;
    #1;
    check("async_reset_dataout", dataout, 32'h0);
    ticks(2);
    resetn = 1'b1;
    ticks(5);
    rd(32'h80, 32'h0, "post_rst_edge6");
    rd(32'h80, 32'h0000_0F0F, "post_rst_edge7");
    rd(32'h84, 32'h0, "post_rst_p1");
    rd(32'h88, 32'h1, "post_rst_stat");
    rd(32'h88, 32'h0, "post_rst_stat_clr");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
